// File: rtl/branch_ctrl.sv
// PC register and branch-redirect stage: next-PC selection, jal link capture,
// fixed-length flush window and halt. Optional counters under BRANCH_CTRL_STATS_EN.
module branch_ctrl #(
  parameter int unsigned             PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]     RESET_PC     = '0,
  parameter int unsigned             FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                is_jt_jf,
  input  logic                jt_jf_ok,
  input  logic                is_jump,
  input  logic                is_jal,
  input  logic                is_halt,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                flush,
  output logic                branch_taken,
  output logic [PC_WIDTH-1:0] link_addr,
  output logic                halted
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [31:0]         cnt_taken,
  output logic [31:0]         cnt_not_taken
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] link_q, link_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                flush_q, flush_d;
  logic                taken_q, taken_d;
  logic                halted_q, halted_d;
  logic                taken_c;
  logic                run_c;

  assign taken_c = is_jump | is_jal | (is_jt_jf & jt_jf_ok);
  assign run_c   = (state_q == ST_RUN) & ~stall;

  // Next-state and next-output selection; stall holds everything except the pulse.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    link_d   = link_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    taken_d  = 1'b0;
    halted_d = halted_q;
    if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if (is_halt) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else if (taken_c) begin
            pc_d    = target;
            taken_d = 1'b1;
            flush_d = 1'b1;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            state_d = ST_FLUSH;
            if (is_jal) link_d = pc_q + PC_WIDTH'(1);
          end else begin
            pc_d = pc_q + PC_WIDTH'(1);
          end
        end
        ST_FLUSH: begin
          pc_d = pc_q + PC_WIDTH'(1);
          if (cnt_q == '0) begin
            flush_d = 1'b0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_HALT: begin
          flush_d  = 1'b0;
          halted_d = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
          flush_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      link_q   <= '0;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      link_q   <= link_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      taken_q  <= taken_d;
      halted_q <= halted_d;
    end
  end

  assign pc_out       = pc_q;
  assign flush        = flush_q;
  assign branch_taken = taken_q;
  assign link_addr    = link_q;
  assign halted       = halted_q;

`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] cnt_taken_q, cnt_taken_d;
  logic [31:0] cnt_nt_q, cnt_nt_d;
  logic        acc_taken_c;
  logic        acc_nt_c;

  assign acc_taken_c = run_c & ~is_halt & taken_c;
  assign acc_nt_c    = run_c & is_jt_jf & ~jt_jf_ok;

  // Saturating event counters.
  always_comb begin
    cnt_taken_d = cnt_taken_q;
    cnt_nt_d    = cnt_nt_q;
    if (acc_taken_c && (cnt_taken_q != '1)) cnt_taken_d = cnt_taken_q + 32'd1;
    if (acc_nt_c && (cnt_nt_q != '1))       cnt_nt_d    = cnt_nt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_taken_q <= '0;
      cnt_nt_q    <= '0;
    end else begin
      cnt_taken_q <= cnt_taken_d;
      cnt_nt_q    <= cnt_nt_d;
    end
  end

  assign cnt_taken     = cnt_taken_q;
  assign cnt_not_taken = cnt_nt_q;
`else
  logic unused_run_c;
  assign unused_run_c = run_c;
`endif

endmodule
